fp_adder_pipe: RTL and testbench
================================

Name: fp_adder_pipe

Overview:
Pipelined IEEE-754 floating-point adder/subtractor, parametrised for single (X=32) or double (X=64) precision. It replaces the combinational adder in the FPU datapath. It accepts one operation per cycle under a valid/ready handshake, has fixed 3-cycle latency, adds guard/round/sticky rounding, and reports overflow, underflow and invalid flags per result.

Parameters:
X, 32, operand width; only 32 or 64 legal
EXPO_BITS, (X==32)?8:11, exponent width, derived
MANT_BITS, (X==32)?23:52, stored fraction width, derived

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle
in_ready  output  1  block accepts operands this cycle
A  input  X  operand A
B  input  X  operand B
sub  input  1  1: compute A-B (invert B sign); 0: A+B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  X  result
overflow  output  1  result overflowed to infinity
underflow  output  1  result flushed to zero
invalid  output  1  NaN produced from non-NaN inputs (inf - inf)

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset: all stage valid bits 0; out, overflow, underflow, invalid = 0; out_valid = 0; in_ready = 1. Asserting rst_n low mid-operation discards in-flight operations with no output.
- Handshake:
  - Global advance enable en = !out_valid | out_ready; in_ready = en.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - When en=0, every stage holds, and out and the flags stay stable.
  - Bubbles propagate as valid=0. Throughput is 1 op/cycle with no stall.
- Latency: an operation accepted at edge N presents out_valid after edge N+3 when there is no stall.
- Stage 1, unpack/align:
  - Split sign, exponent and fraction. exp==0 is treated as signed zero (subnormal inputs flushed).
  - Hidden bit is 1 for normal operands.
  - Swap so operand L has the larger magnitude, comparing {exp,frac}.
  - Shift S right by d = expL-expS into a MANT_BITS+4 bit field plus G, R and sticky; sticky = OR of bits shifted out.
  - If d >= MANT_BITS+3, S becomes 0 with sticky = |S.
  - Specials are decided here and bypass arithmetic:
    - Any NaN input gives canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0) with invalid=0.
    - +inf plus -inf (after sub) gives qNaN with invalid=1.
    - A single inf, or same-sign infs, gives that inf.
- Stage 2, add/sub:
  - Effective subtract when signs differ; magnitude = L+S or L-S, never negative.
  - Result sign = sign of L.
  - An exact zero result from unlike signs is +0. Like-sign zeros keep their sign (-0 + -0 = -0).
- Stage 3, normalise/round:
  - On carry out: shift right 1, fold the lost bit into sticky, exp+1.
  - Otherwise: leading-zero count, shift left, exp minus count.
  - Round per the Optional Feature. A rounding carry renormalises (exp+1).
  - Biased exp >= all-ones gives ±inf with overflow=1.
  - Biased exp <= 0 gives signed zero with underflow=1.
- Flags are registered with out and valid only while out_valid=1; they are 0 for bubbles.

Optional Feature:
- Macro: FP_ADDER_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Increment when G & (R | sticky | lsb).
- Undefined: truncate (round toward zero); G/R/sticky are computed but ignored.
- Specials, flags and latency are identical in both builds.

Test Plan:
- X=32, A=0x3F800000, B=0x3F800000, sub=0 -> out=0x40000000 three cycles after accept; flags 0. X=64: 0x3FF0000000000000 + 0x4000000000000000 -> 0x4008000000000000.
- X=32, 0x3FC00000 + 0xBFC00000 -> 0x00000000 (+0). 0x7F800000 + 0xFF800000 -> 0x7FC00000 with invalid=1. 0x7FC00001 + 0x3F800000 -> 0x7FC00000 with invalid=0.
- X=32, 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow=1. 0x00C00000 - 0x00800000 (sub=1) -> 0x00000000 with underflow=1.
- Rounding: 0x3F800000 + 0x33C00000 -> 0x3F800001 with macro defined, 0x3F800000 without. Tie case 0x3F800000 + 0x33800000 -> 0x3F800000 in both builds.
- Back-to-back stream of 8 ops with out_ready held low for 4 cycles mid-stream -> in_ready=0 while out_valid & !out_ready; out stable; no loss or duplication; results in order.
- Assert rst_n low with 3 ops in flight -> out_valid=0 and flags 0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_adder_pipe.sv
// Pipelined IEEE-754 adder/subtractor (X=32 or 64): input register, align, add, normalise/round.
// Define FP_ADDER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fp_adder_pipe #(
    parameter int X         = 32,
    parameter int EXPO_BITS = (X == 32) ? 8 : 11,
    parameter int MANT_BITS = (X == 32) ? 23 : 52
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [X-1:0] A,
    input  logic [X-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [X-1:0] out,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int E   = EXPO_BITS;
    localparam int M   = MANT_BITS;
    localparam int F   = M + 4;
    localparam int EW  = E + 2;
    localparam int LZW = $clog2(F + 1);

    localparam logic [E-1:0]          DMAX     = E'(M + 3);
    localparam logic signed [EW-1:0]  EXP_MAX  = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0]  EXP_ZERO = '0;
    localparam logic signed [EW-1:0]  EXP_ONE  = EW'(1);
    localparam logic [X-1:0]          QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

`ifdef FP_ADDER_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic         v0, sub0;
    logic [X-1:0] a0, b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            a0   <= '0;
            b0   <= '0;
            sub0 <= 1'b0;
        end else if (en) begin
            v0   <= in_valid;
            a0   <= A;
            b0   <= B;
            sub0 <= sub;
        end
    end

    // Stage 1: unpack, order by magnitude, align the smaller operand, resolve specials.
    logic           sa, sb, sl, ss, swap;
    logic [E-1:0]   ea, eb, el, es, d;
    logic [M-1:0]   fa, fb, fl, fs;
    logic           a_nan, b_nan, a_inf, b_inf;
    logic [M:0]     sig_l, sig_s;
    logic [2*F-1:0] ext;
    logic [F-1:0]   al_s;
    logic           spec;
    logic [X-1:0]   spec_val;
    logic           spec_inv;

    always_comb begin
        sa    = a0[X-1];
        sb    = b0[X-1] ^ sub0;
        ea    = a0[X-2:M];
        eb    = b0[X-2:M];
        fa    = a0[M-1:0];
        fb    = b0[M-1:0];
        a_nan = (&ea) && (|fa);
        b_nan = (&eb) && (|fb);
        a_inf = (&ea) && !(|fa);
        b_inf = (&eb) && !(|fb);
        swap  = {eb, fb} > {ea, fa};
        sl    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        fl    = swap ? fb : fa;
        fs    = swap ? fa : fb;
        sig_l = (|el) ? {1'b1, fl} : '0;
        sig_s = (|es) ? {1'b1, fs} : '0;
        d     = el - es;
        ext   = {sig_s, 3'b000, {F{1'b0}}} >> d;
        if (d >= DMAX) begin
            al_s = {{(F-1){1'b0}}, |sig_s};
        end else begin
            al_s = {ext[2*F-1:F+1], ext[F] | (|ext[F-1:0])};
        end
        spec     = a_nan || b_nan || a_inf || b_inf;
        spec_val = '0;
        spec_inv = 1'b0;
        if (a_nan || b_nan) begin
            spec_val = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_val = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_val = {sa, {E{1'b1}}, {M{1'b0}}};
        end else if (b_inf) begin
            spec_val = {sb, {E{1'b1}}, {M{1'b0}}};
        end
    end

    logic         v1, spec1, inv1, sl1, ss1;
    logic [X-1:0] sval1;
    logic [E-1:0] el1;
    logic [F-1:0] ml1, ms1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            spec1 <= 1'b0;
            inv1  <= 1'b0;
            sval1 <= '0;
            sl1   <= 1'b0;
            ss1   <= 1'b0;
            el1   <= '0;
            ml1   <= '0;
            ms1   <= '0;
        end else if (en) begin
            v1    <= v0;
            spec1 <= spec;
            inv1  <= spec_inv;
            sval1 <= spec_val;
            sl1   <= sl;
            ss1   <= ss;
            el1   <= el;
            ml1   <= {sig_l, 3'b000};
            ms1   <= al_s;
        end
    end

    // Stage 2: magnitude add/subtract; L >= S so the difference is never negative.
    logic       eff_sub, sg;
    logic [F:0] sum;

    always_comb begin
        eff_sub = sl1 ^ ss1;
        sum     = eff_sub ? ({1'b0, ml1} - {1'b0, ms1}) : ({1'b0, ml1} + {1'b0, ms1});
        sg      = (eff_sub && (sum == '0)) ? 1'b0 : sl1;
    end

    logic         v2, spec2, inv2, sg2;
    logic [X-1:0] sval2;
    logic [E-1:0] e2;
    logic [F:0]   sum2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            spec2 <= 1'b0;
            inv2  <= 1'b0;
            sval2 <= '0;
            sg2   <= 1'b0;
            e2    <= '0;
            sum2  <= '0;
        end else if (en) begin
            v2    <= v1;
            spec2 <= spec1;
            inv2  <= inv1;
            sval2 <= sval1;
            sg2   <= sg;
            e2    <= el1;
            sum2  <= sum;
        end
    end

    // Stage 3: normalise, round, then range-check the final exponent.
    logic [LZW-1:0]       lz;
    logic                 found, inc, carry, ovf, unf, inv3;
    logic [F-1:0]         norm;
    logic [M:0]           mant;
    logic [M+1:0]         mant_r;
    logic [M-1:0]         frac;
    logic signed [EW-1:0] e_n, e_r;
    logic [X-1:0]         res;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = F - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum2[i]) found = 1'b1;
                else         lz = lz + LZW'(1);
            end
        end
        if (sum2[F]) begin
            norm = {sum2[F:2], sum2[1] | sum2[0]};
            e_n  = $signed({2'b00, e2}) + EXP_ONE;
        end else begin
            norm = sum2[F-1:0] << lz;
            e_n  = $signed({2'b00, e2}) - $signed({{(EW-LZW){1'b0}}, lz});
        end
        mant   = norm[F-1:3];
        inc    = ROUND_NEAREST & norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r = {1'b0, mant} + {{(M+1){1'b0}}, inc};
        carry  = mant_r[M+1];
        frac   = carry ? mant_r[M:1] : mant_r[M-1:0];
        e_r    = e_n + $signed({{(EW-1){1'b0}}, carry});
        res    = '0;
        ovf    = 1'b0;
        unf    = 1'b0;
        inv3   = 1'b0;
        if (spec2) begin
            res  = sval2;
            inv3 = inv2;
        end else if (sum2 == '0) begin
            res = {sg2, {(X-1){1'b0}}};
        end else if (e_r >= EXP_MAX) begin
            res = {sg2, {E{1'b1}}, {M{1'b0}}};
            ovf = 1'b1;
        end else if (e_r <= EXP_ZERO) begin
            res = {sg2, {(X-1){1'b0}}};
            unf = 1'b1;
        end else begin
            res = {sg2, e_r[E-1:0], frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            out       <= v2 ? res  : '0;
            overflow  <= v2 ? ovf  : 1'b0;
            underflow <= v2 ? unf  : 1'b0;
            invalid   <= v2 ? inv3 : 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe: single and double precision, specials, flags,
// rounding (expectation follows FP_ADDER_ROUND_NEAREST_EN), stall stream and async reset.
module tb_fp_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub32, out_valid, out_ready;
    logic [31:0] a32, b32, res32;
    logic        overflow, underflow, invalid;

    logic        in_valid64, in_ready64, sub64, out_valid64, out_ready64;
    logic [63:0] a64, b64, res64;
    logic        overflow64, underflow64, invalid64;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef FP_ADDER_ROUND_NEAREST_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif

    always #5 clk = ~clk;

    fp_adder_pipe #(.X(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a32), .B(b32), .sub(sub32), .out_valid(out_valid), .out_ready(out_ready),
        .out(res32), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    fp_adder_pipe #(.X(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .A(a64), .B(b64), .sub(sub64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out(res64), .overflow(overflow64), .underflow(underflow64), .invalid(invalid64)
    );

    // Issues one 32-bit op and waits (bounded) for its result; lat = -1 on timeout.
    task automatic op32(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
        @(posedge clk); #1;
        a32 = a_i; b32 = b_i; sub32 = s_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        r  = res32;
        fl = {overflow, underflow, invalid};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a32 = '0; b32 = '0; sub32 = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0; sub64 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        tests_run++;
        if ({out_valid, in_ready, overflow, underflow, invalid} !== 5'b01000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl got %b want 01000",
                     {out_valid, in_ready, overflow, underflow, invalid});
        end
        tests_run++;
        if (res32 !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out got %h want 00000000", res32);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [2:0] fl; int lat;
        op32(32'h3F800000, 32'h3F800000, 1'b0, r, fl, lat);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency got %0d want 3", lat);
        end
        tests_run++;
        if ({r, fl} !== {32'h40000000, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL basic_1p1 got %h/%b want 40000000/000", r, fl);
        end
    endtask

    task automatic test_double();
        int lat;
        @(posedge clk); #1;
        a64 = 64'h3FF0000000000000; b64 = 64'h4000000000000000; sub64 = 1'b0; in_valid64 = 1'b1;
        tests_run++;
        if (in_ready64 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dbl_ready got %b want 1", in_ready64);
        end
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (out_valid64) begin
                lat = c;
                break;
            end
        end
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("[TB] FAIL dbl_latency got %0d want 3", lat);
        end
        tests_run++;
        if ({res64, overflow64, underflow64, invalid64} !== {64'h4008000000000000, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL dbl_1p2 got %h/%b want 4008000000000000/000",
                     res64, {overflow64, underflow64, invalid64});
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [31:0] vr [8];
        logic [2:0]  vf [8];
        logic [31:0] r; logic [2:0] fl; int lat;
        va = '{32'h3FC00000, 32'h7F800000, 32'h7FC00001, 32'h80000000,
               32'h40400000, 32'h7F800000, 32'h7F800000, 32'h3F800001};
        vb = '{32'hBFC00000, 32'hFF800000, 32'h3F800000, 32'h80000000,
               32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vr = '{32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
               32'h40000000, 32'h7F800000, 32'h7FC00000, 32'h34000000};
        vf = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
        for (int k = 0; k < 8; k++) begin
            op32(va[k], vb[k], vs[k], r, fl, lat);
            tests_run++;
            if (lat !== 3 || {r, fl} !== {vr[k], vf[k]}) begin
                tests_failed++;
                $display("[TB] FAIL special_%0d got %h/%b lat %0d want %h/%b lat 3",
                         k, r, fl, lat, vr[k], vf[k]);
            end
        end
    endtask

    task automatic test_flags();
        logic [31:0] r; logic [2:0] fl; int lat;
        op32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, fl, lat);
        tests_run++;
        if ({r, fl} !== {32'h7F800000, 3'b100}) begin
            tests_failed++;
            $display("[TB] FAIL overflow got %h/%b want 7F800000/100", r, fl);
        end
        op32(32'h00C00000, 32'h00800000, 1'b1, r, fl, lat);
        tests_run++;
        if ({r, fl} !== {32'h00000000, 3'b010}) begin
            tests_failed++;
            $display("[TB] FAIL underflow got %h/%b want 00000000/010", r, fl);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [2:0] fl; int lat;
        op32(32'h3F800000, 32'h33C00000, 1'b0, r, fl, lat);
        tests_run++;
        if ({r, fl} !== {RND_EXP, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL round_up got %h/%b want %h/000", r, fl, RND_EXP);
        end
        op32(32'h3F800000, 32'h33800000, 1'b0, r, fl, lat);
        tests_run++;
        if ({r, fl} !== {32'h3F800000, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL round_tie got %h/%b want 3F800000/000", r, fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_q [8];
        logic [31:0] exp_q [8];
        logic [31:0] held;
        logic        acc, stalled, in_stall, ready_next, seen;
        int          sent, got, guard, cguard, stall_left;
        a_q   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        exp_q = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        held = '0; sent = 0; got = 0; stalled = 1'b0; in_stall = 1'b0; stall_left = 0;
        @(posedge clk); #1;
        a32 = a_q[0]; b32 = 32'h3F800000; sub32 = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        fork
            begin
                guard = 0;
                while (sent < 8 && guard < 200) begin
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    guard++;
                    if (acc) begin
                        sent++;
                        if (sent < 8) a32 = a_q[sent];
                        else          in_valid = 1'b0;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                cguard = 0;
                while (got < 8 && cguard < 200) begin
                    @(negedge clk);
                    cguard++;
                    if (out_valid && out_ready) begin
                        tests_run++;
                        if (res32 !== exp_q[got]) begin
                            tests_failed++;
                            $display("[TB] FAIL stream_%0d got %h want %h", got, res32, exp_q[got]);
                        end
                        got++;
                        in_stall = 1'b0;
                    end else if (out_valid && !out_ready) begin
                        tests_run++;
                        if (in_ready !== 1'b0) begin
                            tests_failed++;
                            $display("[TB] FAIL stall_ready got %b want 0", in_ready);
                        end
                        if (in_stall) begin
                            tests_run++;
                            if (res32 !== held) begin
                                tests_failed++;
                                $display("[TB] FAIL stall_hold got %h want %h", res32, held);
                            end
                        end else begin
                            held = res32;
                        end
                        in_stall = 1'b1;
                    end
                    if (got == 3 && !stalled) begin
                        stalled    = 1'b1;
                        stall_left = 4;
                    end
                    ready_next = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                    @(posedge clk); #2;
                    out_ready = ready_next;
                end
                out_ready = 1'b1;
            end
        join
        tests_run++;
        if (sent !== 8 || got !== 8) begin
            tests_failed++;
            $display("[TB] FAIL stream_count got sent %0d recv %0d want 8/8", sent, got);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stream_extra got out_valid %b want 0", seen);
        end
    endtask

    task automatic test_reset_in_flight();
        logic seen;
        @(posedge clk); #1;
        a32 = 32'h7F800000; b32 = 32'hFF800000; sub32 = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a32 = 32'h3F800000; b32 = 32'h3F800000;
        @(posedge clk); #1;
        a32 = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({out_valid, invalid} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL flight_first got %b want 11", {out_valid, invalid});
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, overflow, underflow, invalid} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL async_reset got %b want 0000",
                     {out_valid, overflow, underflow, invalid});
        end
        tests_run++;
        if (res32 !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_out got %h want 00000000", res32);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_ready got %b want 1", in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stale_result got out_valid %b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double();
        test_specials();
        test_flags();
        test_rounding();
        test_back_to_back();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
